// File: rtl/light_mixer.sv
// Colour sequencer (manual button or auto prescaler) feeding a white<->colour crossfade.
// Registered light output: one cycle behind colour/alpha; no backpressure, inputs sampled every cycle.
module light_mixer #(
  parameter int CHAN_W    = 8,
  parameter int FADE_BITS = 4,
  parameter int AUTO_DIV  = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button,
  input  logic                sel,
  input  logic                auto,
  output logic [3*CHAN_W-1:0] light,
  output logic [2:0]          colour,
  output logic                fading
);

  localparam int AW = FADE_BITS + 1;
  localparam int MW = CHAN_W + FADE_BITS + 1;
  localparam int PW = $clog2(AUTO_DIV);
  localparam logic [AW-1:0]     A_FULL = AW'(1 << FADE_BITS);
  localparam logic [CHAN_W-1:0] CH_MAX = '1;

  logic              btn_q;
  logic [PW-1:0]     presc;
  logic [AW-1:0]     alpha;
  logic [AW-1:0]     target;
  logic              presc_wrap;
  logic              step;
  logic [3*CHAN_W-1:0] mix;

  assign target     = sel ? A_FULL : '0;
  assign fading     = (alpha != target);
  assign presc_wrap = (presc == PW'(AUTO_DIV - 1));
  assign step       = auto ? presc_wrap : (button & ~btn_q);

  // White term plus colour term; a channel that is on sums back to exactly full scale.
  function automatic logic [CHAN_W-1:0] blend(input logic on, input logic [AW-1:0] a);
    logic [MW-1:0] sum;
    sum = MW'(CH_MAX) * MW'(A_FULL - a) + (on ? MW'(CH_MAX) * MW'(a) : MW'(0));
    return CHAN_W'(sum >> FADE_BITS);
  endfunction

  always_comb begin
    mix = '0;
    for (int c = 0; c < 3; c++) begin
      mix[c*CHAN_W +: CHAN_W] = blend(colour[c], alpha);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      colour <= 3'b001;
      alpha  <= '0;
      presc  <= '0;
      btn_q  <= 1'b0;
      light  <= '1;
    end else begin
      btn_q <= button;
      presc <= (auto && !presc_wrap) ? presc + PW'(1) : '0;
      if (step) begin
        colour <= (colour == 3'b110) ? 3'b001 : colour + 3'd1;
      end
      if (alpha < target) begin
        alpha <= alpha + AW'(1);
      end else if (alpha > target) begin
        alpha <= alpha - AW'(1);
      end
      light <= mix;
    end
  end

endmodule

// File: tb/tb_light_mixer.sv
// Bench for light_mixer with CHAN_W=8, FADE_BITS=2, AUTO_DIV=4: vector table through a scoreboard queue,
// plus hand-written reset and prescaler sequences.
module tb_light_mixer;

  logic        clk;
  logic        rst;
  logic        button;
  logic        sel;
  logic        auto;
  logic [23:0] light;
  logic [2:0]  colour;
  logic        fading;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        button;
    logic        sel;
    logic        auto_m;
    logic [2:0]  colour;
    logic [23:0] light;
    logic        fading;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  light_mixer #(.CHAN_W(8), .FADE_BITS(2), .AUTO_DIV(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .sel    (sel),
    .auto   (auto),
    .light  (light),
    .colour (colour),
    .fading (fading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] expand(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  function automatic void add(input logic b, input logic s, input logic a,
                              input logic [2:0] c, input logic [23:0] l, input logic f);
    vec_t v;
    v.button = b; v.sel = s; v.auto_m = a; v.colour = c; v.light = l; v.fading = f;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [2:0] seq [6];
    logic [2:0] c_prev;
    logic [2:0] c_now;
    vec_t exp_v;

    seq[0] = 3'b010; seq[1] = 3'b011; seq[2] = 3'b100;
    seq[3] = 3'b101; seq[4] = 3'b110; seq[5] = 3'b001;

    // Manual stepping with wrap, sel=0 so light stays white.
    for (int i = 0; i < 6; i++) begin
      add(1'b1, 1'b0, 1'b0, seq[i], 24'hFFFFFF, 1'b0);
      add(1'b0, 1'b0, 1'b0, seq[i], 24'hFFFFFF, 1'b0);
    end
    // Held button: exactly one step.
    for (int i = 0; i < 10; i++) add(1'b1, 1'b0, 1'b0, 3'b010, 24'hFFFFFF, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b010, 24'hFFFFFF, 1'b0);
    for (int i = 1; i < 6; i++) begin
      add(1'b1, 1'b0, 1'b0, seq[i], 24'hFFFFFF, 1'b0);
      add(1'b0, 1'b0, 1'b0, seq[i], 24'hFFFFFF, 1'b0);
    end
    // Crossfade to colour 001.
    add(1'b0, 1'b1, 1'b0, 3'b001, 24'hFFFFFF, 1'b1);
    add(1'b0, 1'b1, 1'b0, 3'b001, 24'hBFBFFF, 1'b1);
    add(1'b0, 1'b1, 1'b0, 3'b001, 24'h7F7FFF, 1'b1);
    add(1'b0, 1'b1, 1'b0, 3'b001, 24'h3F3FFF, 1'b0);
    add(1'b0, 1'b1, 1'b0, 3'b001, 24'h0000FF, 1'b0);
    // Full fade back to white.
    add(1'b0, 1'b0, 1'b0, 3'b001, 24'h0000FF, 1'b1);
    add(1'b0, 1'b0, 1'b0, 3'b001, 24'h3F3FFF, 1'b1);
    add(1'b0, 1'b0, 1'b0, 3'b001, 24'h7F7FFF, 1'b1);
    add(1'b0, 1'b0, 1'b0, 3'b001, 24'hBFBFFF, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b001, 24'hFFFFFF, 1'b0);
    // Reversal at alpha=2.
    add(1'b0, 1'b1, 1'b0, 3'b001, 24'hFFFFFF, 1'b1);
    add(1'b0, 1'b1, 1'b0, 3'b001, 24'hBFBFFF, 1'b1);
    add(1'b0, 1'b0, 1'b0, 3'b001, 24'h7F7FFF, 1'b1);
    add(1'b0, 1'b0, 1'b0, 3'b001, 24'hBFBFFF, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b001, 24'hFFFFFF, 1'b0);
    // Step on the same edge as sel rises.
    add(1'b1, 1'b1, 1'b0, 3'b010, 24'hFFFFFF, 1'b1);
    add(1'b0, 1'b1, 1'b0, 3'b010, 24'hBFFFBF, 1'b1);
    add(1'b0, 1'b1, 1'b0, 3'b010, 24'h7FFF7F, 1'b1);
    add(1'b0, 1'b1, 1'b0, 3'b010, 24'h3FFF3F, 1'b0);
    add(1'b0, 1'b1, 1'b0, 3'b010, 24'h00FF00, 1'b0);
    // Auto mode: step every 4th edge, button toggling ignored.
    c_prev = 3'b010;
    for (int i = 1; i <= 12; i++) begin
      c_now = (i < 4) ? 3'b010 : (i < 8) ? 3'b011 : (i < 12) ? 3'b100 : 3'b101;
      add(1'(i % 2), 1'b1, 1'b1, c_now, expand(c_prev), 1'b0);
      c_prev = c_now;
    end
    for (int i = 0; i < 6; i++) add(1'b0, 1'b1, 1'b0, 3'b101, 24'hFF00FF, 1'b0);

    // Reset and mid-fade reset.
    rst = 1'b0; button = 1'b0; sel = 1'b0; auto = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_light", light, 24'hFFFFFF);
    chk("reset_colour", colour, 3'b001);
    chk("reset_fading", fading, 1'b0);
    rst = 1'b1;
    sel = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("prefade_light", light, 24'hBFBFFF);
    #2;
    rst = 1'b0;
    #1;
    chk("midfade_rst_light", light, 24'hFFFFFF);
    chk("midfade_rst_colour", colour, 3'b001);
    chk("midfade_rst_fading", fading, 1'b1);
    sel = 1'b0;
    #1;
    chk("rst_sel0_fading", fading, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_fading", fading, 1'b0);

    // Table vectors through the scoreboard.
    for (int i = 0; i < tbl.size(); i++) begin
      button = tbl[i].button;
      sel    = tbl[i].sel;
      auto   = tbl[i].auto_m;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        exp_v = sb.pop_front();
        chk($sformatf("v%0d_colour", i), colour, exp_v.colour);
        chk($sformatf("v%0d_light", i), light, exp_v.light);
        chk($sformatf("v%0d_fading", i), fading, exp_v.fading);
      end
    end
    chk("presc_idle", dut.presc, 0);

    // Button already high at the first edge after reset release steps once.
    rst = 1'b0; sel = 1'b0; auto = 1'b0; button = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_btn_colour", colour, 3'b010);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_hold_colour", colour, 3'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/light_mixer.md
# light_mixer

Parametrised successor to the team's white/RGB light selector. It holds a colour sequencer that is stepped manually by `button` or advanced automatically by a prescaler. The 3-bit colour code is expanded to full-scale RGB channels of configurable width. Changes of `sel` produce a linear crossfade between white and the selected colour instead of an instant switch. The block sits between the board's button/switch inputs and the light driver, and its `light` output is registered.

## Interface

Parameters:

- `CHAN_W`, default 8: bits per colour channel. `light` is 3*CHAN_W wide.
- `FADE_BITS`, default 4: a full crossfade takes 2^FADE_BITS cycles.
- `AUTO_DIV`, default 1000000: cycles per colour step in auto mode. Must be at least 2.

Ports:

- `clk`, input, 1 bit: single clock; all state changes on its rising edge.
- `rst`, input, 1 bit: asynchronous, active-low reset.
- `button`, input, 1 bit: colour step request, already synchronous to `clk`. Its rising edge is used.
- `sel`, input, 1 bit: 0 = white target, 1 = colour target.
- `auto`, input, 1 bit: 1 = the prescaler steps the colour; `button` is ignored.
- `light`, output, 3*CHAN_W bits: registered mix. Packing is `[3*CHAN_W-1:2*CHAN_W]`=R, `[2*CHAN_W-1:CHAN_W]`=G, `[CHAN_W-1:0]`=B.
- `colour`, output, 3 bits: current colour code. Bit 2 = R, bit 1 = G, bit 0 = B.
- `fading`, output, 1 bit: high while the mix ratio differs from the `sel` target.

## Operation

- **Colour sequence.** The code takes the values 001, 010, 011, 100, 101, 110, then wraps to 001. Codes 000 and 111 are never produced.
- **Manual step.**
  - The block registers `button` into `btn_q`.
  - A step condition is `button & ~btn_q` while `auto`=0.
  - Holding `button` high produces exactly one step.
- **Auto step.**
  - The prescaler counts 0..AUTO_DIV-1 while `auto`=1. The colour steps on the cycle the count equals AUTO_DIV-1, and the count then returns to 0.
  - While `auto`=0, the prescaler is held at 0.
  - `btn_q` keeps tracking `button` in both modes.
- **Channel expansion.** Each code bit maps to a channel value: 1 → all ones (2^CHAN_W-1), 0 → 0. White is all ones on every channel.
- **Mix ratio.**
  - `alpha` is FADE_BITS+1 bits wide and ranges over 0..A, where A = 2^FADE_BITS.
  - The target is A when `sel`=1 and 0 when `sel`=0.
  - Each cycle, `alpha` moves 1 toward the target. It saturates at 0 and at A.
  - Toggling `sel` mid-fade reverses direction from the current `alpha`; `alpha` never jumps.
- **Output, per channel c.**
  - `light_c` = (W·(A−alpha) + C_c·alpha) >> FADE_BITS, where W is the white channel value (all ones) and C_c is the expanded colour channel.
  - The intermediate width is CHAN_W+FADE_BITS+1 bits, with no overflow.
  - `alpha`=0 gives exactly white; `alpha`=A gives exactly the colour.
- **Colour change during a fade.** A colour change takes effect in the mix immediately; colours are not faded into each other. `alpha` continues unaffected.
- **`fading` output.** `fading` = (`alpha` ≠ target), computed combinationally from the `alpha` register and `sel`.

## Timing

- **Reset (`rst`=0).** Forces, asynchronously:
  - colour index → code 001
  - `alpha` = 0
  - prescaler = 0
  - `btn_q` = 0
  - `light` = all ones (white)
- **After reset release.** The first rising edge is normal operation. If `button` is already high at that edge, it counts as a rising edge and steps the colour.
- **Step latency.** On a step at edge k, `colour` updates at edge k and `light` reflects the new colour at edge k+1.
- **`sel` latency.**
  - `sel` changing before edge k moves `alpha` at edge k; `light` shows the first intermediate value at edge k+1.
  - A full fade completes with `alpha` at the target at edge k+A−1 and `light` final at edge k+A.
- **Simultaneous events.** A step and a `sel` change in the same cycle are both applied at the same edge.
- **Mid-fade reset.** Reset during a fade returns `light` to white immediately, with no fade out.

## Test plan

All scenarios use CHAN_W=8, FADE_BITS=2 (A=4) and AUTO_DIV=4.

1. **Reset.** Assert `rst`=0 with `sel`=1 mid-fade → `light`=0xFFFFFF, `colour`=001 and `fading`=1 immediately, with no clock required. Hold `sel`=0 and release `rst` → `fading`=0.
2. **Manual stepping with wrap.** Apply 6 separate `button` pulses with `auto`=0 → `colour` goes 010, 011, 100, 101, 110, 001. Hold `button` high for 10 cycles → exactly one step.
3. **Crossfade to colour.** With `colour`=001, set `sel` 0→1 → `light` sequence is 0xBFBFFF, 0x7F7FFF, 0x3F3FFF, 0x0000FF. `fading` is high for exactly 4 cycles.
4. **Fade reversal.** With `colour`=001, drop `sel` back to 0 after `light`=0x7F7FFF → `light` goes 0xBFBFFF, then 0xFFFFFF. `fading` deasserts with `alpha`=0.
5. **Auto mode.** Set `auto`=1, `sel`=1, settled → `colour` steps every 4 cycles. `button` pulses are ignored. Set `auto`=0 → stepping stops and the prescaler reads 0.
6. **Colour change mid-fade.** With `colour`=001, apply a `button` step at the same edge as `sel` rises → the first `light` value after that edge is 0xBFFFBF (colour 010 with `alpha`=1).
